// File: rtl/line_fill_arbiter.sv
// Round-robin arbiter sharing one word-wide memory between the I-cache miss port
// and the D-cache line port; each grant moves one LINE_WORDS-word line beat by beat.
module line_fill_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int LINE_WORDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state | meaning
    // IDLE  | no grant; arbitrate between i_req and d_req
    // BURST | granted side owns memory; one handshake per beat
    // DONE  | one-cycle done pulse to the granted side

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                     grant_d;
    logic                     last_d;
    logic                     we_q;
    logic [ADDR_W-BEAT_W-1:0] base_hi;
    logic [BEAT_W-1:0]        beat;
    logic                     pick_d;
    logic                     in_burst;
    logic                     rd_ack;

    // On a tie the side that did not win last time is picked.
    assign pick_d   = d_req && (!i_req || !last_d);
    assign in_burst = (state == S_BURST);
    assign rd_ack   = in_burst && mem_ack && !we_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_req || d_req) state_nxt = S_BURST;
            S_BURST: if (mem_ack && beat == LAST_BEAT) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_d  <= 1'b0;
            last_d   <= 1'b1;
            we_q     <= 1'b0;
            base_hi  <= '0;
            beat     <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            i_rvalid <= rd_ack && !grant_d;
            d_rvalid <= rd_ack && grant_d;
            if (state == S_IDLE && (i_req || d_req)) begin
                grant_d <= pick_d;
                last_d  <= pick_d;
                we_q    <= pick_d && d_we;
                base_hi <= pick_d ? d_addr[ADDR_W-1:BEAT_W] : i_addr[ADDR_W-1:BEAT_W];
                beat    <= '0;
            end
            if (in_burst && mem_ack) begin
                // Beat wraps to 0 after the last word; it never carries into base_hi.
                beat <= beat + 1'b1;
            end
            if (rd_ack) begin
                if (grant_d) d_rdata <= mem_rdata;
                else         i_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = in_burst;
    assign mem_we    = in_burst && we_q;
    assign mem_addr  = in_burst ? {base_hi, beat} : '0;
    assign mem_wdata = (in_burst && we_q) ? d_wdata : '0;
    assign d_wready  = in_burst && we_q && mem_ack;
    assign i_done    = (state == S_DONE) && !grant_d;
    assign d_done    = (state == S_DONE) && grant_d;

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Directed bench for line_fill_arbiter with a variable-latency memory model and
// a monitor that logs beats, returned words and done pulses.
module tb_line_fill_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic          i_rvalid, i_done, d_wready, d_rvalid, d_done;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clock = ~clock;

    line_fill_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LINE_WORDS(4)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    int   lat    = 1;
    logic exp_we = 1'b0;
    int   cnt    = 0;

    int n_ack = 0, n_irv = 0, n_drv = 0, n_idone = 0, n_ddone = 0, n_wr = 0;
    int we_err = 0, wd_err = 0;
    logic [AW-1:0] a_log [128];
    logic [DW-1:0] i_log [128];
    logic [DW-1:0] d_log [128];
    logic [DW-1:0] w_log [128];

    int wcnt  = 0;
    int wbase = 0;
    assign d_wdata = 32'hD000_0000 + 32'(wcnt - wbase);

    logic [2*DW*2+AW+7:0] all_outs;
    assign all_outs = {mem_req, mem_we, mem_addr, mem_wdata, i_rvalid, i_done, i_rdata,
                       d_rvalid, d_done, d_wready, d_rdata};

    function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
        return {6'h2A, a, 6'h15, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Memory answers lat cycles after each beat is presented; monitor samples late in the cycle.
    always @(negedge clock) begin
        if (mem_req) begin
            cnt++;
            if (cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = fdat(mem_addr);
                cnt       = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            cnt       = 0;
        end
        #2;
        if (mem_ack && mem_req) begin
            a_log[n_ack & 127] = mem_addr;
            if (mem_we !== exp_we) we_err++;
            if (mem_we) begin
                w_log[n_ack & 127] = mem_wdata;
                if (mem_wdata !== d_wdata) wd_err++;
            end
            n_ack++;
        end
        if (d_wready) n_wr++;
        if (i_rvalid) begin i_log[n_irv & 127] = i_rdata; n_irv++; end
        if (d_rvalid) begin d_log[n_drv & 127] = d_rdata; n_drv++; end
        if (i_done) n_idone++;
        if (d_done) n_ddone++;
    end

    // Requester advances its writeback word after the edge that consumed it.
    always @(posedge clock) begin
        #1;
        wcnt = n_wr;
    end

    task automatic wait_done(input int budget, output int cyc, output int side);
        cyc  = 0;
        side = 0;
        for (int k = 0; k < budget && side == 0; k++) begin
            @(posedge clock);
            #1;
            cyc++;
            if (i_done) side = 1;
            else if (d_done) side = 2;
        end
        chk("done_seen", 32'(side != 0), 1);
    endtask

    task automatic wait_acks(input int base, input int n);
        for (int k = 0; k < 60; k++) begin
            @(posedge clock);
            #1;
            if (n_ack - base >= n) break;
        end
        chk("acks_seen", 32'(n_ack - base >= n), 1);
    endtask

    task automatic settle();
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, side;
        int a0, r0, id0, dd0, dq0, iq0, wr0, we0, wd0;

        reset  = 1'b0;
        i_req  = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        i_addr = '0;
        d_addr = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_outs", 32'(|all_outs), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        reset = 1'b1;
        settle();

        // I-only line at 0x047 -> 0x044..0x047, ack after 1 cycle; done 5 edges after req.
        a0 = n_ack; r0 = n_irv; id0 = n_idone; dq0 = n_drv + n_ddone + n_wr;
        lat = 1; exp_we = 1'b0;
        i_addr = 10'h047; i_req = 1'b1;
        wait_done(50, cyc, side);
        i_req = 1'b0;
        chk("i_side", 32'(side), 1);
        chk("i_cycles", 32'(cyc), 5);
        settle();
        chk("i_nack", 32'(n_ack - a0), 4);
        for (int k = 0; k < 4; k++) begin
            chk("i_addr", 32'(a_log[(a0 + k) & 127]), 32'h044 + 32'(k));
            chk("i_data", i_log[(r0 + k) & 127], fdat(10'(10'h044 + k)));
        end
        chk("i_nrvalid", 32'(n_irv - r0), 4);
        chk("i_ndone", 32'(n_idone - id0), 1);
        chk("i_dquiet", 32'(n_drv + n_ddone + n_wr - dq0), 0);

        // D writeback at 0x120, ack latency 3 -> 4*3 + 1 edges to done.
        a0 = n_ack; dd0 = n_ddone; iq0 = n_irv + n_idone; wr0 = n_wr;
        we0 = we_err; wd0 = wd_err; r0 = n_drv;
        wbase = wcnt;
        lat = 3; exp_we = 1'b1;
        d_addr = 10'h120; d_we = 1'b1; d_req = 1'b1;
        wait_done(100, cyc, side);
        d_req = 1'b0; d_we = 1'b0;
        chk("wb_side", 32'(side), 2);
        chk("wb_cycles", 32'(cyc), 13);
        settle();
        chk("wb_nwready", 32'(n_wr - wr0), 4);
        for (int k = 0; k < 4; k++) begin
            chk("wb_addr", 32'(a_log[(a0 + k) & 127]), 32'h120 + 32'(k));
            chk("wb_wdata", w_log[(a0 + k) & 127], 32'hD000_0000 + 32'(k));
        end
        chk("wb_we_err", 32'(we_err - we0), 0);
        chk("wb_track_err", 32'(wd_err - wd0), 0);
        chk("wb_ndone", 32'(n_ddone - dd0), 1);
        chk("wb_iquiet", 32'(n_irv + n_idone - iq0), 0);
        chk("wb_no_rvalid", 32'(n_drv - r0), 0);

        // Reset while the D refill is at beat 2: burst aborted, no done pulse.
        a0 = n_ack; dd0 = n_ddone;
        lat = 2; exp_we = 1'b0;
        d_addr = 10'h080; d_req = 1'b1;
        wait_acks(a0, 2);
        reset = 1'b0;
        #1;
        chk("midrst_outs", 32'(|all_outs), 0);
        chk("midrst_mem_req", 32'(mem_req), 0);
        d_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        settle();
        chk("midrst_nodone", 32'(n_ddone - dd0), 0);

        // Tie straight after reset: I wins, then the held D request is served.
        a0 = n_ack;
        lat = 1; exp_we = 1'b0;
        i_addr = 10'h010; d_addr = 10'h030; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        wait_done(50, cyc, side);
        i_req = 1'b0;
        chk("tie1_first", 32'(side), 1);
        wait_done(50, cyc, side);
        d_req = 1'b0;
        chk("tie1_second", 32'(side), 2);
        settle();
        chk("tie1_addr_i", 32'(a_log[a0 & 127]), 32'h010);
        chk("tie1_addr_d", 32'(a_log[(a0 + 4) & 127]), 32'h030);

        // I-only line at 0x3FF stays inside 0x3FC..0x3FF; leaves last grant = I.
        a0 = n_ack;
        i_addr = 10'h3FF; i_req = 1'b1;
        wait_done(50, cyc, side);
        i_req = 1'b0;
        settle();
        for (int k = 0; k < 4; k++)
            chk("top_addr", 32'(a_log[(a0 + k) & 127]), 32'h3FC + 32'(k));

        // Tie after an I grant: D goes first this time.
        a0 = n_ack;
        i_addr = 10'h050; d_addr = 10'h060;
        i_req = 1'b1; d_req = 1'b1;
        wait_done(50, cyc, side);
        d_req = 1'b0;
        chk("tie2_first", 32'(side), 2);
        wait_done(50, cyc, side);
        i_req = 1'b0;
        chk("tie2_second", 32'(side), 1);
        settle();
        chk("tie2_addr_d", 32'(a_log[a0 & 127]), 32'h060);
        chk("tie2_addr_i", 32'(a_log[(a0 + 4) & 127]), 32'h050);

        // D refill at 0x202; address and we changed mid-burst must be ignored.
        a0 = n_ack; r0 = n_drv; wr0 = n_wr; we0 = we_err;
        d_addr = 10'h202; d_we = 1'b0; d_req = 1'b1;
        wait_acks(a0, 2);
        d_addr = 10'h3FC; d_we = 1'b1;
        wait_done(50, cyc, side);
        d_req = 1'b0; d_we = 1'b0;
        chk("rf_side", 32'(side), 2);
        settle();
        for (int k = 0; k < 4; k++) begin
            chk("rf_addr", 32'(a_log[(a0 + k) & 127]), 32'h200 + 32'(k));
            chk("rf_data", d_log[(r0 + k) & 127], fdat(10'(10'h200 + k)));
        end
        chk("rf_nrvalid", 32'(n_drv - r0), 4);
        chk("rf_nowready", 32'(n_wr - wr0), 0);
        chk("rf_we_err", 32'(we_err - we0), 0);

        // No request: memory stays idle.
        a0 = n_ack;
        repeat (5) @(posedge clock);
        #1;
        chk("idle_mem_req", 32'(mem_req), 0);
        chk("idle_nack", 32'(n_ack - a0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
